// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Register-file write-back arbiter for five functional units (ALU, MEM, MUL,
//   DIV, JUMP). Each FU owns one holding buffer. A handshake loads the buffer
//   at the clock edge. Each cycle, one buffered entry is selected
//   combinationally from buffer state, and that entry drives the write port.
//   Selection is round-robin when RR_EN=1 and fixed priority (index 0 highest)
//   when RR_EN=0. A handshake with rd=0 is accepted and dropped.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous reset, active low
//   req_valid  : [4:0]   per-FU result valid
//   req_rd     : [24:0]  packed destination regs, [5i+4:5i] for FU i
//   req_data   : [159:0] packed result data, [32i+31:32i] for FU i
//   req_ready  : [4:0]   per-FU accept
//   wb_we      : register-file write enable
//   wb_rd      : [4:0]   write address
//   wb_data    : [31:0]  write data
//   wb_fu      : [2:0]   granted FU index, 7 when idle
//   pending    : [31:0]  registers targeted by buffered entries (bit 0 always 0)
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   req_valid,
    input  logic [24:0]  req_rd,
    input  logic [159:0] req_data,
    output logic [4:0]   req_ready,
    output logic         wb_we,
    output logic [4:0]   wb_rd,
    output logic [31:0]  wb_data,
    output logic [2:0]   wb_fu,
    output logic [31:0]  pending
);

    localparam int unsigned NFU = 5;

    logic [NFU-1:0] v;
    logic [4:0]     rd_q   [NFU];
    logic [31:0]    data_q [NFU];
    logic [2:0]     ptr;

    logic [NFU-1:0] grant;
    logic [2:0]     gidx;
    logic           gany;
    logic [3:0]     cand;
    logic [NFU-1:0] waw_block;
    logic [NFU-1:0] load;

    // Grant selection. The search starts at ptr in round-robin mode and at 0
    // in fixed-priority mode. While reset is held, nothing is granted, so
    // buffered results are discarded without being written.
    always_comb begin
        grant = '0;
        gidx  = '0;
        gany  = 1'b0;
        cand  = '0;
        if (rst) begin
            for (int unsigned off = 0; off < NFU; off++) begin
                cand = (RR_EN != 0) ? ({1'b0, ptr} + off[3:0]) : off[3:0];
                if (cand >= 4'd5)
                    cand = cand - 4'd5;
                if (!gany && v[cand[2:0]]) begin
                    gany = 1'b1;
                    gidx = cand[2:0];
                end
            end
        end
        if (gany)
            grant[gidx] = 1'b1;
    end

    // Write port and pending scoreboard
    always_comb begin
        wb_we   = gany;
        wb_rd   = '0;
        wb_data = '0;
        wb_fu   = 3'd7;
        if (gany) begin
            wb_rd   = rd_q[gidx];
            wb_data = data_q[gidx];
            wb_fu   = gidx;
        end
        pending = '0;
        if (rst) begin
            for (int unsigned i = 0; i < NFU; i++) begin
                if (v[i])
                    pending[rd_q[i]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

    // WAW protection. An incoming rd may not overlap a buffered entry that
    // stays buffered past this cycle. When two FUs present the same rd in the
    // same cycle, the lower index has precedence.
    always_comb begin
        waw_block = '0;
        req_ready = '0;
        load      = '0;
        for (int unsigned i = 0; i < NFU; i++) begin
            for (int unsigned j = 0; j < NFU; j++) begin
                if (j != i && v[j] && !grant[j] && rd_q[j] == req_rd[5*i +: 5])
                    waw_block[i] = 1'b1;
                if (j < i && req_valid[j] && req_rd[5*j +: 5] == req_rd[5*i +: 5])
                    waw_block[i] = 1'b1;
            end
            if (req_rd[5*i +: 5] == 5'd0)
                waw_block[i] = 1'b0;
            req_ready[i] = rst & (~v[i] | grant[i]) & ~waw_block[i];
            load[i]      = req_valid[i] & req_ready[i] & (req_rd[5*i +: 5] != 5'd0);
        end
    end

    // A refill takes precedence over the grant-clear of the same buffer. The
    // old entry is still written this cycle through the combinational grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v   <= '0;
            ptr <= '0;
        end else begin
            for (int unsigned i = 0; i < NFU; i++) begin
                if (load[i]) begin
                    v[i]      <= 1'b1;
                    rd_q[i]   <= req_rd[5*i +: 5];
                    data_q[i] <= req_data[32*i +: 32];
                end else if (grant[i]) begin
                    v[i] <= 1'b0;
                end
            end
            if (RR_EN != 0 && gany)
                ptr <= (gidx == 3'd4) ? 3'd0 : gidx + 3'd1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//   Self-checking bench for wb_arbiter (RR_EN=1). A behavioural model of the
//   five holding buffers and the rotating search start predicts every output
//   on every cycle. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int RR = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   req_valid;
    logic [24:0]  req_rd;
    logic [159:0] req_data;
    logic [4:0]   req_ready;
    logic         wb_we;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;
    logic [2:0]   wb_fu;
    logic [31:0]  pending;

    wb_arbiter #(.RR_EN(RR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(req_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_fu(wb_fu),
        .pending(pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    bit         mv    [5];
    bit [4:0]   mrd   [5];
    bit [31:0]  mdata [5];
    int         mptr = 0;

    // Model predictions
    int         e_g;
    bit         e_we;
    bit [4:0]   e_rd;
    bit [31:0]  e_data;
    bit [2:0]   e_fu;
    bit [31:0]  e_pend;
    bit [4:0]   e_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_eval();
        bit [4:0] r;
        bit       blk;
        int       idx;
        e_g = -1;
        if (rst) begin
            for (int off = 0; off < 5; off++) begin
                idx = (RR != 0) ? (mptr + off) % 5 : off;
                if (e_g < 0 && mv[idx]) e_g = idx;
            end
        end
        e_we   = (e_g >= 0);
        e_rd   = e_we ? mrd[e_g]   : 5'd0;
        e_data = e_we ? mdata[e_g] : 32'd0;
        e_fu   = e_we ? 3'(e_g)    : 3'd7;
        e_pend = '0;
        if (rst)
            for (int i = 0; i < 5; i++) if (mv[i]) e_pend[mrd[i]] = 1'b1;
        e_pend[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r   = req_rd[5*i +: 5];
            blk = 1'b0;
            if (r != 0) begin
                for (int j = 0; j < 5; j++)
                    if (j != i && mv[j] && mrd[j] == r && e_g != j) blk = 1'b1;
                for (int k = 0; k < i; k++)
                    if (req_valid[k] && req_rd[5*k +: 5] == r) blk = 1'b1;
            end
            e_ready[i] = rst && (!mv[i] || e_g == i) && !blk;
        end
    endfunction

    // Model state advance at each rising edge
    always @(posedge clk) begin
        model_eval();
        if (!rst) begin
            for (int i = 0; i < 5; i++) mv[i] = 1'b0;
            mptr = 0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (req_valid[i] && e_ready[i] && req_rd[5*i +: 5] != 0) begin
                    mv[i]    = 1'b1;
                    mrd[i]   = req_rd[5*i +: 5];
                    mdata[i] = req_data[32*i +: 32];
                end else if (e_g == i) begin
                    mv[i] = 1'b0;
                end
            end
            if (RR != 0 && e_g >= 0) mptr = (e_g + 1) % 5;
        end
    end

    // Per-cycle compare, 1 time unit after inputs change at the falling edge
    always @(negedge clk) begin
        #1;
        model_eval();
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("wb_we",     32'(wb_we),     32'(e_we));
        chk("wb_rd",     32'(wb_rd),     32'(e_rd));
        chk("wb_data",   wb_data,        e_data);
        chk("wb_fu",     32'(wb_fu),     32'(e_fu));
        chk("pending",   pending,        e_pend);
    end

    function automatic logic [24:0] rdv(input int i, input logic [4:0] r);
        return 25'(r) << (5*i);
    endfunction

    function automatic logic [159:0] dv(input int i, input logic [31:0] d);
        return 160'(d) << (32*i);
    endfunction

    task automatic tick(input logic r, input logic [4:0] v, input logic [24:0] rds, input logic [159:0] dat);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_rd    = rds;
        req_data  = dat;
        #2;
    endtask

    task automatic idle();
        tick(1'b1, 5'b0, '0, '0);
    endtask

    task automatic do_reset();
        tick(1'b0, 5'b0, '0, '0);
        chk("rst_we",      32'(wb_we),     32'd0);
        chk("rst_fu",      32'(wb_fu),     32'd7);
        chk("rst_ready",   32'(req_ready), 32'd0);
        chk("rst_pending", pending,        32'd0);
    endtask

    initial begin
        rst = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;
        do_reset();
        do_reset();

        // Single ALU write, one-cycle latency
        tick(1'b1, 5'b00001, rdv(0, 5'd5), dv(0, 32'h1234));
        chk("s1_ready", 32'(req_ready[0]), 32'd1);
        chk("s1_nowe",  32'(wb_we),        32'd0);
        idle();
        chk("s1_we",    32'(wb_we),  32'd1);
        chk("s1_rd",    32'(wb_rd),  32'd5);
        chk("s1_data",  wb_data,     32'h1234);
        chk("s1_fu",    32'(wb_fu),  32'd0);
        chk("s1_pend",  pending,     32'h20);
        idle();
        chk("s1_we2",   32'(wb_we),  32'd0);
        chk("s1_pend2", pending,     32'd0);

        // All five FUs at once, round-robin from 0
        do_reset();
        tick(1'b1, 5'b11111,
             rdv(0,5'd1) | rdv(1,5'd2) | rdv(2,5'd3) | rdv(3,5'd4) | rdv(4,5'd5),
             dv(0,32'hA0) | dv(1,32'hA1) | dv(2,32'hA2) | dv(3,32'hA3) | dv(4,32'hA4));
        chk("s2_ready", 32'(req_ready), 32'h1F);
        for (int c = 0; c < 5; c++) begin
            idle();
            chk("s2_fu",   32'(wb_fu), 32'(c));
            chk("s2_rd",   32'(wb_rd), 32'(c + 1));
            chk("s2_data", wb_data,    32'hA0 + 32'(c));
        end
        tick(1'b1, 5'b10001, rdv(0,5'd9) | rdv(4,5'd10), dv(0,32'h9) | dv(4,32'hA));
        idle();
        chk("s2_wrap0", 32'(wb_fu), 32'd0);
        idle();
        chk("s2_wrap4", 32'(wb_fu), 32'd4);
        idle();

        // WAW: ALU rd7 is blocked behind a buffered MUL rd7
        do_reset();
        tick(1'b1, 5'b00111, rdv(0,5'd3) | rdv(1,5'd4) | rdv(2,5'd7), dv(2,32'h77));
        tick(1'b1, 5'b00101, rdv(0,5'd7) | rdv(2,5'd7), dv(0,32'h70) | dv(2,32'h78));
        chk("s3_blk1", 32'(req_ready[0]), 32'd0);
        chk("s3_fu1",  32'(wb_fu),        32'd0);
        tick(1'b1, 5'b00101, rdv(0,5'd7) | rdv(2,5'd7), dv(0,32'h70) | dv(2,32'h78));
        chk("s3_blk2", 32'(req_ready[0]), 32'd0);
        tick(1'b1, 5'b00101, rdv(0,5'd7) | rdv(2,5'd7), dv(0,32'h70) | dv(2,32'h78));
        chk("s3_mulw", 32'(wb_fu),        32'd2);
        chk("s3_ok",   32'(req_ready[0]), 32'd1);
        chk("s3_mulb", 32'(req_ready[2]), 32'd0);
        idle();
        chk("s3_alu",  32'(wb_fu),   32'd0);
        chk("s3_ald",  wb_data,      32'h70);
        idle();

        // JUMP rd0 is dropped
        do_reset();
        tick(1'b1, 5'b10000, rdv(4,5'd0), dv(4,32'hFFFF));
        chk("s4_ready", 32'(req_ready[4]), 32'd1);
        for (int c = 0; c < 3; c++) begin
            idle();
            chk("s4_we",   32'(wb_we), 32'd0);
            chk("s4_pend", pending,    32'd0);
        end

        // Reset mid-operation discards buffered results
        do_reset();
        tick(1'b1, 5'b01001, rdv(0,5'd1) | rdv(3,5'd2), dv(0,32'h11) | dv(3,32'h22));
        do_reset();
        idle();
        chk("s5_we",  32'(wb_we), 32'd0);
        chk("s5_fu",  32'(wb_fu), 32'd7);
        tick(1'b1, 5'b10010, rdv(1,5'd4) | rdv(4,5'd3), '0);
        idle();
        chk("s5_ptr", 32'(wb_fu), 32'd1);
        idle();
        idle();

        // Back-to-back ALU stream with same-cycle refill
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 5'b00001, rdv(0, 5'(c + 1)), dv(0, 32'h100 + 32'(c)));
            chk("s6_ready", 32'(req_ready[0]), 32'd1);
            if (c > 0) begin
                chk("s6_we", 32'(wb_we), 32'd1);
                chk("s6_rd", 32'(wb_rd), 32'(c));
            end
        end
        idle();
        chk("s6_we3", 32'(wb_we), 32'd1);
        chk("s6_rd3", 32'(wb_rd), 32'd3);
        idle();
        chk("s6_end", 32'(wb_we), 32'd0);

        // Randomized traffic with a small rd range to force WAW collisions
        for (int c = 0; c < 3000; c++) begin
            logic [24:0]  rds;
            logic [159:0] dat;
            for (int i = 0; i < 5; i++) begin
                rds[5*i +: 5]  = 5'($urandom_range(0, 7));
                dat[32*i +: 32] = $urandom;
            end
            tick(($urandom_range(0, 49) != 0), 5'($urandom), rds, dat);
        end

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
